// File: rtl/game_sequencer.sv
// Pong game-flow controller: score counters, serve timing and phase sequencing.
// Drives the score display and gates the ball datapath.
module game_sequencer #(
    parameter int WIN_SCORE   = 11,
    parameter int SERVE_DELAY = 60,
    parameter int OVER_DELAY  = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic       ball_enable,
    output logic       serve,
    output logic       serve_dir,
    output logic       attract,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ATTRACT    = 2'd0,
        SERVE_WAIT = 2'd1,
        PLAY       = 2'd2,
        GAME_OVER  = 2'd3
    } state_t;

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY - 1);
    localparam logic [7:0] OVER_LAST  = 8'(OVER_DELAY - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] left_q, left_d;
    logic [3:0] right_q, right_d;
    logic       start_q;
    logic       serve_q, serve_d;
    logic       dir_q, dir_d;
    logic       start_rise;
    logic [3:0] left_inc, right_inc;

    assign start_rise = start & ~start_q;
    assign left_inc   = left_q + 4'd1;
    assign right_inc  = right_q + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ATTRACT;
            cnt_q   <= 8'd0;
            left_q  <= 4'd0;
            right_q <= 4'd0;
            start_q <= 1'b0;
            serve_q <= 1'b0;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            right_q <= right_d;
            start_q <= start;
            serve_q <= serve_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        right_d = right_q;
        serve_d = 1'b0;
        dir_d   = dir_q;
        unique case (state_q)
            ATTRACT: begin
                if (start_rise) begin
                    left_d  = 4'd0;
                    right_d = 4'd0;
                    dir_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = SERVE_WAIT;
                end
            end
            SERVE_WAIT: begin
                if (frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        cnt_d   = 8'd0;
                        serve_d = 1'b1;
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            PLAY: begin
                // miss_left has priority when both edges report in one cycle
                if (miss_left) begin
                    right_d = right_inc;
                    dir_d   = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = (right_inc == WIN) ? GAME_OVER : SERVE_WAIT;
                end else if (miss_right) begin
                    left_d  = left_inc;
                    dir_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = (left_inc == WIN) ? GAME_OVER : SERVE_WAIT;
                end
            end
            GAME_OVER: begin
                if (frame_tick) begin
                    if (cnt_q == OVER_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = ATTRACT;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ATTRACT;
        endcase
    end

    assign left_score  = left_q;
    assign right_score = right_q;
    assign serve       = serve_q;
    assign serve_dir   = dir_q;
    assign attract     = (state_q == ATTRACT);
    assign game_over   = (state_q == GAME_OVER);
    assign ball_enable = (state_q == ATTRACT) || (state_q == PLAY);

endmodule
